restoring_divider: RTL and testbench

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider.sv | 128 ++++++++++++
 tb/tb_restoring_divider.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock, WIDTH iterations.
// Divide-by-zero bypasses the iteration and reports all-ones quotient with the dividend as remainder.
module restoring_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PR_W  = WIDTH + 1;
  localparam int unsigned SH_W  = 2 * WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PR_W-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   q_res_q, q_res_d;
  logic [WIDTH-1:0]   r_res_q, r_res_d;
  logic               dbz_q, dbz_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [SH_W-1:0]    shifted;
  logic [PR_W-1:0]    trial;

  // Next-state, datapath iteration and result capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    q_res_d = q_res_q;
    r_res_d = r_res_q;
    dbz_d   = dbz_q;
    shifted = '0;
    trial   = '0;

    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            state_d = DONE;
            q_res_d = '1;
            r_res_d = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            rem_d   = '0;
            quo_d   = dividend;
            cnt_d   = CNT_W'(WIDTH);
          end
        end
      end

      RUN: begin
        shifted = {rem_q, quo_q} << 1;
        // Trial MSB set means a borrow: restore the shifted remainder.
        trial   = shifted[SH_W-1:WIDTH] - {1'b0, dvs_q};
        rem_d   = trial[WIDTH] ? shifted[SH_W-1:WIDTH] : trial;
        quo_d   = shifted[WIDTH-1:0] | WIDTH'(!trial[WIDTH]);
        cnt_d   = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          q_res_d = quo_d;
          r_res_d = rem_d[WIDTH-1:0];
          dbz_d   = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_d = (state_d == RUN);
  assign done_d = (state_d == DONE);

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      q_res_q <= '0;
      r_res_q <= '0;
      dbz_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      q_res_q <= q_res_d;
      r_res_q <= r_res_d;
      dbz_q   <= dbz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = q_res_q;
  assign remainder   = r_res_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Self-checking bench for restoring_divider (WIDTH=4): directed cases, back-to-back sweep
// of all operand pairs, and randomized operations against an arithmetic reference model.
module tb_restoring_divider;

  localparam int unsigned WIDTH = 4;
  localparam int          MAXV  = (1 << WIDTH) - 1;
  localparam int          TMO   = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int n_checks = 0;
  int n_errors = 0;

  restoring_divider #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_q(input int a, input int b);
    return (b == 0) ? MAXV : a / b;
  endfunction

  function automatic int ref_r(input int a, input int b);
    return (b == 0) ? a : a % b;
  endfunction

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int a, input int b);
    check({tag, ".q"}, int'(quotient), ref_q(a, b));
    check({tag, ".r"}, int'(remainder), ref_r(a, b));
    check({tag, ".dbz"}, int'(div_by_zero), (b == 0) ? 1 : 0);
    if (b != 0) begin
      check({tag, ".ident"}, int'(quotient) * b + int'(remainder), a);
      check({tag, ".rlt"}, (int'(remainder) < b) ? 1 : 0, 1);
    end
  endtask

  // Single operation with a start pulse; checks latency, busy length, result and done width.
  task automatic run_op(input int a, input int b, input string tag);
    int lat;
    int busy_cnt;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    start    = 1'b1;
    tick();
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < TMO) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, ".lat"}, lat, (b == 0) ? 0 : WIDTH);
    check({tag, ".busy"}, busy_cnt, (b == 0) ? 0 : WIDTH);
    check_result(tag, a, b);
    tick();
    check({tag, ".done1"}, int'(done), 0);
    check({tag, ".hold"}, int'(quotient), ref_q(a, b));
  endtask

  initial begin
    int a;
    int b;
    int lat;
    int pulses;
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    tick();
    tick();
    check("rst.busy", int'(busy), 0);
    check("rst.done", int'(done), 0);
    check("rst.q", int'(quotient), 0);
    check("rst.r", int'(remainder), 0);
    check("rst.dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();

    run_op(13, 3, "d13_3");
    run_op(7, 0, "d7_0");
    run_op(15, 1, "d15_1");
    run_op(2, 5, "d2_5");
    run_op(0, 9, "d0_9");

    // Start held high: second operation is accepted on the DONE edge.
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    tick();
    dividend = 4'd14;
    divisor  = 4'd4;
    for (int i = 0; i < WIDTH; i++) begin
      check("b2b.busy1", int'(busy), 1);
      tick();
    end
    check("b2b.done1", int'(done), 1);
    check_result("b2b.first", 9, 2);
    tick();
    check("b2b.rerun", int'(busy), 1);
    check("b2b.nodone", int'(done), 0);
    dividend = 4'd1;
    divisor  = 4'd1;
    lat = 1;
    while (!done && lat < TMO) begin
      tick();
      lat++;
    end
    check("b2b.lat2", lat, WIDTH + 1);
    check_result("b2b.second", 14, 4);
    start = 1'b0;
    tick();
    check("b2b.end", int'(done), 0);

    // Reset aborts a division in progress.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", int'(busy), 0);
    check("abort.done", int'(done), 0);
    check("abort.q", int'(quotient), 0);
    check("abort.r", int'(remainder), 0);
    check("abort.dbz", int'(div_by_zero), 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done || busy) pulses++;
    end
    check("abort.quiet", pulses, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    divisor = 4'd3;
    tick();
    rst = 1'b0;
    start = 1'b0;
    check("rstpri.busy", int'(busy), 0);
    check("rstpri.done", int'(done), 0);
    tick();

    // Exhaustive sweep of all pairs, streamed back-to-back with start held high.
    dividend = 4'd0;
    divisor  = 4'd0;
    start    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      a = i >> 4;
      b = i & 15;
      tick();
      dividend = WIDTH'((i + 1) >> 4);
      divisor  = WIDTH'((i + 1) & 15);
      lat = 0;
      while (!done && lat < TMO) begin
        tick();
        lat++;
      end
      check("sweep.lat", lat, (b == 0) ? 0 : WIDTH);
      check_result("sweep", a, b);
    end
    start = 1'b0;
    tick();

    // Randomized operands with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(MAXV, 0));
      b = int'($urandom_range(MAXV, 0));
      run_op(a, b, "rand");
      for (int g = int'($urandom_range(2, 0)); g > 0; g--) tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
